// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM states, frame payload,
// and the byte-select helper used when presenting frame bytes to the UART.
package uart_pkg;

    localparam logic [7:0]  TAG_BASE_DEF     = 8'hA0;
    localparam int unsigned BUSY_TIMEOUT_DEF = 16;
    localparam int unsigned FRAME_BYTES      = 3;
    localparam int unsigned WORD_W           = 16;
    localparam int unsigned SRC_W            = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0]        tag;
        logic [WORD_W-1:0] word;
    } frame_t;

    // Byte order on the wire: tag, word high byte, word low byte.
    function automatic logic [7:0] frame_byte(input frame_t f, input logic [1:0] idx);
        case (idx)
            2'd0:    return f.tag;
            2'd1:    return f.word[15:8];
            default: return f.word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin select: first set request at or after ptr, wrapping upward.
// Reusable for any shared resource with up to four requesters.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] win_onehot_c,
    output logic [1:0]   win_idx_c,
    output logic         win_valid_c
);

    logic       hit_hi;
    logic       hit_lo;
    logic [1:0] idx_hi;
    logic [1:0] idx_lo;

    // Lowest request at/above ptr wins; otherwise wrap to the lowest request overall.
    always_comb begin
        hit_hi       = 1'b0;
        hit_lo       = 1'b0;
        idx_hi       = '0;
        idx_lo       = '0;
        win_onehot_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!hit_hi && req[i] && (i >= 32'(ptr))) begin
                hit_hi = 1'b1;
                idx_hi = 2'(i);
            end
            if (!hit_lo && req[i]) begin
                hit_lo = 1'b1;
                idx_lo = 2'(i);
            end
        end
        win_valid_c = hit_lo;
        win_idx_c   = hit_hi ? idx_hi : idx_lo;
        for (int unsigned i = 0; i < N; i++) begin
            win_onehot_c[i] = win_valid_c && (win_idx_c == 2'(i));
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte UART between NUM_REQ sources; each grant sends tag, data hi, data lo,
// with a busy-rise timeout so a silent transmitter cannot stall the frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_W       = WORD_W,
    parameter logic [7:0]  TAG_BASE     = TAG_BASE_DEF,
    parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      frame_done,
    output logic                      timeout_err,
    output logic [SRC_W-1:0]          active_src,
    output logic                      busy_o,
    output logic [7:0]                uart_byte,
    output logic                      uart_start,
    input  logic                      uart_busy
);

    localparam int unsigned      CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [1:0]       LAST_IDX = 2'(FRAME_BYTES - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] sel_q, sel_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    frame_t             frame_q, frame_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic [7:0]         byte_q, byte_d;
    logic               start_q, start_d;
    logic               advance;

    logic [NUM_REQ-1:0] win_oh;
    logic [SRC_W-1:0]   win_idx;
    logic               win_valid;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req          (req),
        .ptr          (ptr_q),
        .win_onehot_c (win_oh),
        .win_idx_c    (win_idx),
        .win_valid_c  (win_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            frame_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            byte_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            byte_q  <= byte_d;
            start_q <= start_d;
        end
    end

    // Next state and next registered outputs; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        busy_d  = busy_q;
        byte_d  = byte_q;
        start_d = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ena && win_valid) begin
                    sel_d   = win_oh;
                    src_d   = win_idx;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frame_d.tag = TAG_BASE | 8'(src_q);
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (src_q == SRC_W'(i)) begin
                        frame_d.word = req_data[i*DATA_W +: WORD_W];
                    end
                end
                gnt_d   = sel_q;
                idx_d   = '0;
                ptr_d   = (32'(src_q) + 32'd1 >= NUM_REQ) ? '0 : src_q + SRC_W'(1);
                state_d = ST_START;
            end
            ST_START: begin
                byte_d  = frame_byte(frame_q, idx_q);
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (uart_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == CNT_MAX) begin
                    tmo_d   = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!uart_busy) begin
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte is finished either by the busy fall or by an abandoned start.
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 2'd1;
                state_d = ST_START;
            end
        end
    end

    assign gnt         = gnt_q;
    assign frame_done  = done_q;
    assign timeout_err = tmo_q;
    assign active_src  = src_q;
    assign busy_o      = busy_q;
    assign uart_byte   = byte_q;
    assign uart_start  = start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter with a behavioural UART and a
// round-robin/frame reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned N   = 3;
    localparam logic [7:0]  TAG = 8'hA0;
    localparam int unsigned TMO = 16;

    logic           clk;
    logic           rst_n;
    logic           ena;
    logic [N-1:0]   req;
    logic [N*16-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           frame_done;
    logic           timeout_err;
    logic [1:0]     active_src;
    logic           busy_o;
    logic [7:0]     uart_byte;
    logic           uart_start;
    logic           uart_busy;

    uart_tx_arbiter #(
        .NUM_REQ(N), .DATA_W(16), .TAG_BASE(TAG), .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .req_data(req_data),
        .gnt(gnt), .frame_done(frame_done), .timeout_err(timeout_err),
        .active_src(active_src), .busy_o(busy_o), .uart_byte(uart_byte),
        .uart_start(uart_start), .uart_busy(uart_busy)
    );

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int rise_dly = 2;
    int busy_len = 10;
    bit never_busy = 1'b0;

    logic [7:0] byte_q[$];
    int start_cyc_q[$];
    int gnt_idx_q[$];
    int gnt_cyc_q[$];
    int to_cyc_q[$];
    int fd_cyc_q[$];

    logic [15:0] wd [N];
    int mptr, c0, c1, w, seen;
    logic [N-1:0] mask;
    int exp_src [4];
    logic [15:0] exp_word [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy rises rise_dly cycles after a start, stays busy_len cycles.
    initial begin
        int pend, rem;
        pend = 0;
        rem = 0;
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pend = 0; rem = 0; uart_busy = 1'b0;
            end else if (uart_start && !never_busy) begin
                pend = rise_dly;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin uart_busy = 1'b1; rem = busy_len; end
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) uart_busy = 1'b0;
            end
        end
    end

    // Event monitor
    always @(negedge clk) begin
        logic [N-1:0] sh;
        if (uart_start === 1'b1) begin
            byte_q.push_back(uart_byte);
            start_cyc_q.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            sh = gnt >> i;
            if (sh[0] === 1'b1) begin gnt_idx_q.push_back(i); gnt_cyc_q.push_back(cyc); end
        end
        if (timeout_err === 1'b1) to_cyc_q.push_back(cyc);
        if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // Reference round-robin: first requester at or after p, wrapping.
    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        logic [N-1:0] sh;
        for (int off = 0; off < N; off++) begin
            sh = m >> ((p + off) % N);
            if (sh[0]) return (p + off) % N;
        end
        return -1;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < N; i++) req_data[i*16 +: 16] = wd[i];
    endtask

    task automatic clear_mon();
        byte_q.delete(); start_cyc_q.delete(); gnt_idx_q.delete();
        gnt_cyc_q.delete(); to_cyc_q.delete(); fd_cyc_q.delete();
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        while (gnt === '0 && n < 400) begin tick(); n++; end
        check({tag, "_gnt_seen"}, 32'(gnt !== '0), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 600) begin tick(); n++; end
        check({tag, "_done_seen"}, 32'(frame_done === 1'b1), 32'd1);
    endtask

    task automatic wait_starts(input string tag, input int cnt);
        int n = 0;
        while (start_cyc_q.size() < cnt && n < 400) begin tick(); n++; end
        check({tag, "_starts"}, 32'(start_cyc_q.size() >= cnt), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_active_src"}, 32'(active_src), 32'd0);
        check({tag, "_busy_o"}, 32'(busy_o), 32'd0);
        check({tag, "_uart_byte"}, 32'(uart_byte), 32'd0);
        check({tag, "_uart_start"}, 32'(uart_start), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int src, input logic [15:0] wv);
        logic [7:0] b;
        check({tag, "_nbytes"}, 32'(byte_q.size()), 32'd3);
        if (byte_q.size() == 3) begin
            b = byte_q.pop_front();
            check({tag, "_byte_tag"}, 32'(b), 32'(TAG | 8'(src)));
            b = byte_q.pop_front();
            check({tag, "_byte_hi"}, 32'(b), 32'(wv[15:8]));
            b = byte_q.pop_front();
            check({tag, "_byte_lo"}, 32'(b), 32'(wv[7:0]));
        end
        byte_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; req = '0; req_data = '0; mptr = 0;
        for (int i = 0; i < N; i++) wd[i] = '0;
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();
        check_quiet("idle");

        // Single request
        clear_mon();
        wd[0] = 16'h0191; drive_data();
        ena = 1'b1; req = 3'b001; c0 = cyc;
        w = rr_pick(req, mptr); mptr = (w + 1) % N;
        wait_gnt("single");
        req = '0;
        check("single_gnt", 32'(gnt), 32'(3'b001));
        check("single_active_src", 32'(active_src), 32'(w));
        check("single_busy_o", 32'(busy_o), 32'd1);
        check("single_gnt_latency", 32'(qget(gnt_cyc_q, 0) - c0), 32'd2);
        wait_done("single");
        check("single_busy_at_done", 32'(busy_o), 32'd0);
        check("single_start_latency", 32'(qget(start_cyc_q, 0) - c0), 32'd3);
        check_frame("single", w, 16'h0191);
        tick();
        check("single_busy_after", 32'(busy_o), 32'd0);
        check("single_ngnt", 32'(gnt_idx_q.size()), 32'd1);
        check("single_ndone", 32'(fd_cyc_q.size()), 32'd1);

        // Contention from reset
        rst_n = 1'b0; req = 3'b011; ena = 1'b1; rise_dly = 1; busy_len = 3;
        for (int i = 0; i < N; i++) wd[i] = 16'($urandom);
        drive_data();
        tick(); tick();
        clear_mon(); mptr = 0;
        rst_n = 1'b1;
        for (int f = 0; f < 4; f++) begin
            exp_src[f] = rr_pick(3'b011, mptr); mptr = (exp_src[f] + 1) % N;
            wait_done("cont");
            check_frame("cont", exp_src[f], wd[exp_src[f]]);
            if (f == 3) req = '0;
            tick();
        end
        for (int k = 0; k < 4; k++) check("cont_gnt_order", 32'(qget(gnt_idx_q, k)), 32'(exp_src[k]));
        for (int k = 0; k < 3; k++)
            check("cont_gap", 32'(qget(gnt_cyc_q, k + 1) - qget(fd_cyc_q, k)), 32'd2);

        // Busy never rises
        clear_mon(); never_busy = 1'b1;
        wd[0] = 16'hBEEF; drive_data(); req = 3'b001;
        w = rr_pick(req, mptr); mptr = (w + 1) % N;
        wait_gnt("tmo");
        req = '0;
        wait_done("tmo");
        check_frame("tmo", w, 16'hBEEF);
        check("tmo_count", 32'(to_cyc_q.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            check("tmo_delay", 32'(qget(to_cyc_q, k) - qget(start_cyc_q, k)), 32'd16);
        never_busy = 1'b0; rise_dly = 2; busy_len = 10;
        tick();

        // Data changes after the grant must not reach the wire
        clear_mon();
        wd[0] = 16'h1234; drive_data(); req = 3'b001;
        w = rr_pick(req, mptr); mptr = (w + 1) % N;
        wait_gnt("stable");
        req = '0;
        tick();
        wd[0] = 16'hFFFF; drive_data();
        wait_done("stable");
        check_frame("stable", w, 16'h1234);
        tick();

        // ena dropped mid-frame
        clear_mon(); rise_dly = 2; busy_len = 6;
        for (int i = 0; i < N; i++) wd[i] = 16'($urandom);
        drive_data(); req = 3'b011;
        w = rr_pick(req, mptr); mptr = (w + 1) % N;
        exp_word[0] = wd[w];
        wait_gnt("ena");
        check("ena_gnt", 32'(gnt), 32'(3'b001 << w));
        wait_starts("ena_byte1", 2);
        ena = 1'b0;
        wait_done("ena");
        check_frame("ena", w, exp_word[0]);
        seen = 0;
        repeat (20) begin tick(); if (gnt !== '0 || busy_o !== 1'b0) seen++; end
        check("ena_no_grant", 32'(seen), 32'd0);
        c1 = cyc; ena = 1'b1;
        w = rr_pick(req, mptr); mptr = (w + 1) % N;
        exp_word[0] = wd[w];
        wait_gnt("ena_resume");
        check("ena_resume_latency", 32'(cyc - c1), 32'd2);
        check("ena_resume_gnt", 32'(gnt), 32'(3'b001 << w));
        req = '0;
        wait_done("ena_resume");
        check_frame("ena_resume", w, exp_word[0]);
        tick();

        // Reset during WAIT_LO of byte 1
        clear_mon(); rise_dly = 2; busy_len = 10;
        wd[0] = 16'h5A3C; drive_data(); req = 3'b001;
        w = rr_pick(req, mptr); mptr = (w + 1) % N;
        wait_gnt("mrst");
        req = '0;
        wait_starts("mrst_byte1", 2);
        c0 = 0;
        while (uart_busy !== 1'b1 && c0 < 50) begin tick(); c0++; end
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check_quiet("mrst_async");
        mptr = 0;
        tick(); tick();
        check_quiet("mrst_hold");
        clear_mon();
        wd[0] = 16'hC0DE; wd[1] = 16'h7E57; drive_data(); req = 3'b011;
        rst_n = 1'b1;
        w = rr_pick(req, mptr); mptr = (w + 1) % N;
        wait_gnt("mrst_after");
        check("mrst_after_gnt", 32'(gnt), 32'(3'b001 << w));
        req = '0;
        wait_done("mrst_after");
        check_frame("mrst_after", w, wd[w]);

        // Randomized frames against the reference model
        for (int it = 0; it < 25; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) wd[i] = 16'($urandom);
            drive_data();
            rise_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 8);
            req = mask;
            w = rr_pick(mask, mptr); mptr = (w + 1) % N;
            exp_word[0] = wd[w];
            wait_gnt("rand");
            check("rand_gnt", 32'(gnt), 32'(3'b001 << w));
            check("rand_active_src", 32'(active_src), 32'(w));
            req = N'($urandom_range(0, (1 << N) - 1));
            req_data = {N{16'($urandom)}};
            wait_done("rand");
            check_frame("rand", w, exp_word[0]);
        end
        req = '0;
        repeat (5) tick();
        check("final_busy_o", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
